// File: rtl/ts_pkg.sv
// Shared constants and types for the UDP-to-TS splitter.
//   TS_BYTES/TS_WORDS : one 188-byte TS packet, stored as 47 big-endian words
//   HDR_WORDS         : prefix words emitted ahead of each packet body
//   TS_SYNC           : TS sync byte expected at the start of each packet
//   ts_hdr_t          : per-packet source IP / destination port captured from the datagram
//   out_state_e       : output sequencer states
package ts_pkg;

  localparam int unsigned TS_BYTES    = 188;
  localparam int unsigned TS_WORDS    = 47;
  localparam int unsigned HDR_WORDS   = 3;
  localparam int unsigned BURST_WORDS = HDR_WORDS + TS_WORDS;
  localparam logic [7:0]  TS_SYNC     = 8'h47;
  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned BCNT_W      = 8;

  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] port;
  } ts_hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_BODY
  } out_state_e;

endpackage

// File: rtl/ts_pp_buf.sv
// Ping-pong packet store: two halves of 47x32 words, each with a full flag and
// the header (IP/port) of the packet it holds.
//   clk, rst          : clock, asynchronous active-high reset (clears full flags)
//   i_wr_*            : word write port (half, word address, data)
//   i_done*           : mark a half full and latch its header
//   i_rel*            : release (empty) a half after its last word was read
//   i_rd_half/addr    : combinational read select
//   o_rd_data_c/hdr_c : combinational read data and header of i_rd_half
//   o_full            : registered full flags, bit per half
module ts_pp_buf
  import ts_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic              i_wr_half,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_data,
  input  logic              i_done,
  input  logic              i_done_half,
  input  ts_hdr_t           i_done_hdr,
  input  logic              i_rel,
  input  logic              i_rel_half,
  input  logic              i_rd_half,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [31:0]       o_rd_data_c,
  output ts_hdr_t           o_rd_hdr_c,
  output logic [1:0]        o_full
);

  logic [31:0] r_mem [2][TS_WORDS];
  ts_hdr_t     r_hdr [2];
  logic [1:0]  r_full;

  // Payload storage; contents are only meaningful while the half is full.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_half][i_wr_addr] <= i_wr_data;
  end

  // Done and release never target the same half in one cycle: the writer only
  // completes into an empty half and the reader only releases a full one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full   <= 2'b00;
      r_hdr[0] <= '0;
      r_hdr[1] <= '0;
    end else begin
      if (i_done) begin
        r_full[i_done_half] <= 1'b1;
        r_hdr[i_done_half]  <= i_done_hdr;
      end
      if (i_rel) r_full[i_rel_half] <= 1'b0;
    end
  end

  assign o_rd_data_c = r_mem[i_rd_half][i_rd_addr];
  assign o_rd_hdr_c  = r_hdr[i_rd_half];
  assign o_full      = r_full;

endmodule

// File: rtl/ts_udp_split.sv
// Splits UDP datagrams into 188-byte TS packets and emits each as a 50-word
// burst: {24'h0,PORT_ID}, source IP, {16'h0,dest port}, then 47 payload words.
//   clk, rst           : clock, asynchronous active-high reset
//   udp_din/udp_din_en : datagram byte stream; a low cycle ends the datagram
//   ts_dout/ts_dout_en : framed word stream (zero when not valid)
//   err_cnt            : saturating count of discarded TS packets
// Build option: define TS_SYNC_CHECK_EN to drop packets whose first byte is
// not the TS sync byte (and ignore the rest of that datagram).
module ts_udp_split
  import ts_pkg::*;
#(
  parameter logic [7:0] PORT_ID = 8'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  udp_din,
  input  logic        udp_din_en,
  output logic [31:0] ts_dout,
  output logic        ts_dout_en,
  output logic [15:0] err_cnt
);

  // ---------------- writer ----------------
  logic [2:0]        r_hdr_cnt;
  logic [31:0]       r_ip;
  logic [15:0]       r_port;
  logic [BCNT_W-1:0] r_pay_cnt;
  logic [23:0]       r_word;
  logic              r_wr_half;
  logic              r_drop;   // current packet discarded, swallow its bytes
  logic              r_skip;   // ignore bytes until the datagram ends
  logic [15:0]       r_err_cnt;

  logic [1:0]  w_full;
  logic        w_in_hdr, w_in_pay, w_first, w_last, w_sync_bad, w_full_hit;
  logic        w_keep, w_wr_en, w_done, w_abort, w_err_inc;
  ts_hdr_t     w_done_hdr;

  assign w_in_hdr   = udp_din_en && !r_skip && (r_hdr_cnt < 3'd6);
  assign w_in_pay   = udp_din_en && !r_skip && (r_hdr_cnt == 3'd6);
  assign w_first    = (r_pay_cnt == '0);
  assign w_last     = (r_pay_cnt == BCNT_W'(TS_BYTES - 1));
`ifdef TS_SYNC_CHECK_EN
  assign w_sync_bad = w_in_pay && w_first && (udp_din != TS_SYNC);
`else
  assign w_sync_bad = 1'b0;
`endif
  // Halves are filled and drained in strict alternation, so the target half
  // being full means both are full.
  assign w_full_hit = w_in_pay && w_first && !w_sync_bad && w_full[r_wr_half];
  assign w_keep     = w_in_pay && !w_sync_bad && !r_drop && !w_full_hit;
  assign w_wr_en    = w_keep && (r_pay_cnt[1:0] == 2'b11);
  assign w_done     = w_keep && w_last;
  assign w_abort    = !udp_din_en && !w_first && !r_drop;
  assign w_err_inc  = w_sync_bad || w_full_hit || w_abort;
  assign w_done_hdr = {r_ip, r_port};

  // Byte parsing, packet counting and half selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hdr_cnt <= '0;
      r_ip      <= '0;
      r_port    <= '0;
      r_pay_cnt <= '0;
      r_word    <= '0;
      r_wr_half <= 1'b0;
      r_drop    <= 1'b0;
      r_skip    <= 1'b1;  // a datagram already in flight at reset release is ignored
    end else if (!udp_din_en) begin
      r_hdr_cnt <= '0;
      r_pay_cnt <= '0;
      r_drop    <= 1'b0;
      r_skip    <= 1'b0;
    end else if (w_in_hdr) begin
      r_hdr_cnt <= r_hdr_cnt + 3'd1;
      if (r_hdr_cnt < 3'd4) r_ip   <= {r_ip[23:0], udp_din};
      else                  r_port <= {r_port[7:0], udp_din};
    end else if (w_sync_bad) begin
      r_skip <= 1'b1;
    end else if (w_in_pay) begin
      r_word <= {r_word[15:0], udp_din};
      if (w_full_hit) r_drop <= 1'b1;
      if (w_last) begin
        r_pay_cnt <= '0;
        r_drop    <= 1'b0;
        if (w_keep) r_wr_half <= ~r_wr_half;
      end else begin
        r_pay_cnt <= r_pay_cnt + BCNT_W'(1);
      end
    end
  end

  // Saturating discard counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_err_cnt <= '0;
    else if (w_err_inc && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
  end

  // ---------------- reader ----------------
  out_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt, w_rd_addr;
  logic              r_rd_half, w_rd_half_nxt, w_rel;
  logic [31:0]       r_dout, w_dout_nxt;
  logic              r_dout_en, w_dout_en_nxt;
  logic [31:0]       w_rd_data;
  ts_hdr_t           w_rd_hdr;

  ts_pp_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (w_wr_en),
    .i_wr_half   (r_wr_half),
    .i_wr_addr   (r_pay_cnt[BCNT_W-1:2]),
    .i_wr_data   ({r_word, udp_din}),
    .i_done      (w_done),
    .i_done_half (r_wr_half),
    .i_done_hdr  (w_done_hdr),
    .i_rel       (w_rel),
    .i_rel_half  (r_rd_half),
    .i_rd_half   (r_rd_half),
    .i_rd_addr   (w_rd_addr),
    .o_rd_data_c (w_rd_data),
    .o_rd_hdr_c  (w_rd_hdr),
    .o_full      (w_full)
  );

  // Output sequencer; the registered state always names the word on ts_dout.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_rd_half_nxt = r_rd_half;
    w_rd_addr     = '0;
    w_dout_nxt    = '0;
    w_dout_en_nxt = 1'b0;
    w_rel         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_full[r_rd_half]) begin
          w_state_nxt   = ST_HDR0;
          w_dout_nxt    = {24'h0, PORT_ID};
          w_dout_en_nxt = 1'b1;
        end
      end
      ST_HDR0: begin
        w_state_nxt   = ST_HDR1;
        w_dout_nxt    = w_rd_hdr.ip;
        w_dout_en_nxt = 1'b1;
      end
      ST_HDR1: begin
        w_state_nxt   = ST_HDR2;
        w_dout_nxt    = {16'h0, w_rd_hdr.port};
        w_dout_en_nxt = 1'b1;
      end
      ST_HDR2: begin
        w_state_nxt   = ST_BODY;
        w_idx_nxt     = '0;
        w_dout_nxt    = w_rd_data;
        w_dout_en_nxt = 1'b1;
      end
      ST_BODY: begin
        if (r_idx == ADDR_W'(TS_WORDS - 1)) begin
          w_rel         = 1'b1;
          w_rd_half_nxt = ~r_rd_half;
          if (w_full[~r_rd_half]) begin
            w_state_nxt   = ST_HDR0;
            w_dout_nxt    = {24'h0, PORT_ID};
            w_dout_en_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_idx_nxt     = r_idx + ADDR_W'(1);
          w_rd_addr     = r_idx + ADDR_W'(1);
          w_dout_nxt    = w_rd_data;
          w_dout_en_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_rd_half <= 1'b0;
      r_dout    <= '0;
      r_dout_en <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_rd_half <= w_rd_half_nxt;
      r_dout    <= w_dout_nxt;
      r_dout_en <= w_dout_en_nxt;
    end
  end

  assign ts_dout    = r_dout;
  assign ts_dout_en = r_dout_en;
  assign err_cnt    = r_err_cnt;

endmodule
